// File: rtl/vram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Time-slices six single-port 8-bit VRAM planes between the Z80
//            bus and the gfx fetch unit. Video fetch has priority, the CPU is
//            stretched through wait_n, and CPU accesses apply per-plane
//            read/write bank masks (write broadcast, read OR-merge).
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
    parameter int AW     = 13,
    parameter int PLANES = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    // CPU side
    input  logic                  cpu_req_i,
    input  logic                  cpu_wr_i,
    input  logic [AW-1:0]         cpu_addr_i,
    input  logic [7:0]            cpu_din_i,
    input  logic [PLANES-1:0]     cpu_rd_bank_i,
    input  logic [PLANES-1:0]     cpu_wr_bank_i,
    output logic [7:0]            cpu_q_o,
    output logic                  cpu_ack_o,
    output logic                  cpu_wait_n_o,
    // Video fetch side
    input  logic                  vid_req_i,
    input  logic [AW-1:0]         vid_addr_i,
    output logic [PLANES*8-1:0]   vid_data_o,
    output logic                  vid_ack_o,
    output logic                  vid_ovr_o,
    // Plane RAM bus
    output logic [AW-1:0]         ram_addr_o,
    output logic [7:0]            ram_din_o,
    output logic [PLANES-1:0]     ram_ce_n_o,
    output logic                  ram_wr_n_o,
    input  logic [PLANES*8-1:0]   ram_q_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_VRD   = 3'd1,
        S_VCAP  = 3'd2,
        S_CACC  = 3'd3,
        S_CDONE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       ram_addr_q, ram_addr_d;
    logic [7:0]          ram_din_q, ram_din_d;
    logic [PLANES-1:0]   ram_ce_n_q, ram_ce_n_d;
    logic                ram_wr_n_q, ram_wr_n_d;
    logic [7:0]          cpu_q_q, cpu_q_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic [PLANES*8-1:0] vid_data_q, vid_data_d;
    logic                vid_ack_q, vid_ack_d;
    logic                vid_ovr_q, vid_ovr_d;
    logic                vid_pend_q, vid_pend_d;
    logic [AW-1:0]       vaddr_q, vaddr_d;
    logic                cpu_armed_q, cpu_armed_d;
    logic                cpu_turn_q, cpu_turn_d;
    logic                op_wr_q, op_wr_d;
    logic [PLANES-1:0]   bank_q, bank_d;

    logic                cpu_new;
    logic [7:0]          rd_or;

    // A held request only counts once: armed drops with the ack and re-arms on req low.
    assign cpu_new = cpu_req_i & cpu_armed_q;

    // Combinational so the Z80 is stalled in the very cycle it raises the request.
    assign cpu_wait_n_o = ~(cpu_req_i & cpu_armed_q) | cpu_ack_q;

    // OR-merge of the planes selected for the CPU read in flight.
    always_comb begin
        rd_or = 8'h00;
        for (int p = 0; p < PLANES; p++) begin
            if (bank_q[p]) begin
                rd_or = rd_or | ram_q_i[p*8 +: 8];
            end
        end
    end

    // Next-state, slot sequencing, video latch and CPU arming.
    always_comb begin
        state_d     = state_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        ram_ce_n_d  = ram_ce_n_q;
        ram_wr_n_d  = ram_wr_n_q;
        cpu_q_d     = cpu_q_q;
        cpu_ack_d   = 1'b0;
        vid_data_d  = vid_data_q;
        vid_ack_d   = 1'b0;
        vid_ovr_d   = vid_ovr_q;
        vid_pend_d  = vid_pend_q;
        vaddr_d     = vaddr_q;
        cpu_armed_d = cpu_armed_q;
        cpu_turn_d  = cpu_turn_q;
        op_wr_d     = op_wr_q;
        bank_d      = bank_q;

        // A fetch request landing on an unserved one replaces it and flags overrun.
        if (vid_req_i) begin
            if (vid_pend_q) begin
                vid_ovr_d = 1'b1;
            end
            vid_pend_d = 1'b1;
            vaddr_d    = vid_addr_i;
        end

        case (state_q)
            S_IDLE: begin
                if ((vid_pend_q | vid_req_i) && (!cpu_turn_q || !cpu_new)) begin
                    state_d    = S_VRD;
                    ram_ce_n_d = '0;
                    ram_wr_n_d = 1'b1;
                    if (vid_pend_q) begin
                        // Serve the latched fetch; a same-cycle request simply re-pends.
                        ram_addr_d = vaddr_q;
                        vid_ovr_d  = vid_ovr_q;
                        vid_pend_d = vid_req_i;
                    end else begin
                        // Bus free: serve the fresh request directly.
                        ram_addr_d = vid_addr_i;
                        vid_pend_d = 1'b0;
                    end
                end else if (cpu_new) begin
                    state_d    = S_CACC;
                    ram_addr_d = cpu_addr_i;
                    op_wr_d    = cpu_wr_i;
                    if (cpu_wr_i) begin
                        ram_ce_n_d = ~cpu_wr_bank_i;
                        ram_din_d  = cpu_din_i;
                        ram_wr_n_d = 1'b0;
                        bank_d     = cpu_wr_bank_i;
                    end else begin
                        ram_ce_n_d = ~cpu_rd_bank_i;
                        ram_wr_n_d = 1'b1;
                        bank_d     = cpu_rd_bank_i;
                    end
                end
            end
            S_VRD: begin
                state_d    = S_VCAP;
                ram_ce_n_d = '1;
                ram_wr_n_d = 1'b1;
                // A CPU waiting behind this fetch owns the next slot.
                if (cpu_new) begin
                    cpu_turn_d = 1'b1;
                end
            end
            S_VCAP: begin
                state_d    = S_IDLE;
                vid_data_d = ram_q_i;
                vid_ack_d  = 1'b1;
            end
            S_CACC: begin
                state_d    = S_CDONE;
                ram_ce_n_d = '1;
                ram_wr_n_d = 1'b1;
            end
            S_CDONE: begin
                state_d    = S_IDLE;
                cpu_ack_d  = 1'b1;
                cpu_turn_d = 1'b0;
                cpu_q_d    = op_wr_q ? 8'h00 : rd_or;
            end
            default: begin
                state_d    = S_IDLE;
                ram_ce_n_d = '1;
                ram_wr_n_d = 1'b1;
            end
        endcase

        if (cpu_ack_d) begin
            cpu_armed_d = 1'b0;
        end else if (!cpu_req_i) begin
            cpu_armed_d = 1'b1;
        end
    end

    // State and registered-output update; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_ce_n_q  <= '1;
            ram_wr_n_q  <= 1'b1;
            cpu_q_q     <= '0;
            cpu_ack_q   <= 1'b0;
            vid_data_q  <= '0;
            vid_ack_q   <= 1'b0;
            vid_ovr_q   <= 1'b0;
            vid_pend_q  <= 1'b0;
            vaddr_q     <= '0;
            cpu_armed_q <= 1'b1;
            cpu_turn_q  <= 1'b0;
            op_wr_q     <= 1'b0;
            bank_q      <= '0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            ram_ce_n_q  <= ram_ce_n_d;
            ram_wr_n_q  <= ram_wr_n_d;
            cpu_q_q     <= cpu_q_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_data_q  <= vid_data_d;
            vid_ack_q   <= vid_ack_d;
            vid_ovr_q   <= vid_ovr_d;
            vid_pend_q  <= vid_pend_d;
            vaddr_q     <= vaddr_d;
            cpu_armed_q <= cpu_armed_d;
            cpu_turn_q  <= cpu_turn_d;
            op_wr_q     <= op_wr_d;
            bank_q      <= bank_d;
        end
    end

    assign ram_addr_o = ram_addr_q;
    assign ram_din_o  = ram_din_q;
    assign ram_ce_n_o = ram_ce_n_q;
    assign ram_wr_n_o = ram_wr_n_q;
    assign cpu_q_o    = cpu_q_q;
    assign cpu_ack_o  = cpu_ack_q;
    assign vid_data_o = vid_data_q;
    assign vid_ack_o  = vid_ack_q;
    assign vid_ovr_o  = vid_ovr_q;

endmodule
`default_nettype wire
